uart_tx_fifo: RTL

//  Parametrised UART transmitter with an input FIFO.
//  - Serialises DATA_BITS words LSB-first.
//  - Optional odd/even parity; 1 or 2 stop bits; bit time set by CLKS_PER_BIT.
//  - Host can queue up to FIFO_DEPTH words; queued words go out back-to-back.
//  - Drop-in successor for the single-word UART TX in the UART project.

---
 rtl/uart_tx_fifo.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a circular-buffer FIFO; queued words go out back-to-back.
// tx is registered and lags the FSM state by one cycle, so busy is registered the same way.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tx_start,
    input  logic [DATA_BITS-1:0]        data_in,
    output logic                        ready,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_cnt,
    output logic                        tx,
    output logic                        busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        cnt_next;
    logic [DATA_BITS-1:0] head;
    logic                 push, pop, fifo_empty;

    logic [2:0]           state;
    logic [BW-1:0]        baud;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 par;
    logic                 baud_done;

    assign push       = tx_start && ready;
    assign fifo_empty = (fifo_cnt == '0);
    assign head       = mem[rd_ptr];
    assign baud_done  = (baud == BW'(CLKS_PER_BIT - 1));

    // Pop from IDLE, or at the very end of the last stop bit so the next start bit follows with no gap.
    always_comb begin
        pop = 1'b0;
        if (!fifo_empty) begin
            if (state == S_IDLE)
                pop = 1'b1;
            else if (state == S_STOP && baud_done && bit_idx == 4'(STOP_BITS - 1))
                pop = 1'b1;
        end
        cnt_next = fifo_cnt + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            ready    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            fifo_cnt <= cnt_next;
            ready    <= (cnt_next != CW'(FIFO_DEPTH));
            overflow <= tx_start && !ready;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            par     <= 1'b0;
        end else if (pop) begin
            shift   <= head;
            par     <= (PARITY == 2) ? ^head : ~^head;
            state   <= S_START;
            baud    <= '0;
            bit_idx <= '0;
        end else begin
            case (state)
                S_START: begin
                    if (baud_done) begin
                        state   <= S_DATA;
                        baud    <= '0;
                        bit_idx <= '0;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                S_DATA: begin
                    if (baud_done) begin
                        baud  <= '0;
                        shift <= shift >> 1;
                        if (bit_idx == 4'(DATA_BITS - 1)) begin
                            bit_idx <= '0;
                            state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                S_PARITY: begin
                    if (baud_done) begin
                        state   <= S_STOP;
                        baud    <= '0;
                        bit_idx <= '0;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                S_STOP: begin
                    if (baud_done) begin
                        baud <= '0;
                        if (bit_idx == 4'(STOP_BITS - 1))
                            state <= S_IDLE;
                        else
                            bit_idx <= bit_idx + 4'd1;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx   <= 1'b1;
            busy <= 1'b0;
        end else begin
            case (state)
                S_START:  tx <= 1'b0;
                S_DATA:   tx <= shift[0];
                S_PARITY: tx <= par;
                default:  tx <= 1'b1;
            endcase
            busy <= (state != S_IDLE) || !fifo_empty;
        end
    end
endmodule
